// File: rtl/instr_adr_gen_if.sv
// Instruction address stage bus: redirect/halt requests in, fetch-group address pair out.
// Latency: n/a (signal bundle only).
// Backpressure: inReady from fetch/decode qualifies outValid; redirects ignore inReady.
// Ports: master = address generator (drives out*), slave = fetch/decode + redirect sources.
interface instr_adr_gen_if #(
  parameter int WORD_LENGTH = 32,
  parameter int LANES       = 2
);
  localparam int SW = $clog2(LANES) + 1;

  logic                   inReady;
  logic                   inBrValid;
  logic [WORD_LENGTH-1:0] inBrSeg;
  logic [WORD_LENGTH-1:0] inBrOfs;
  logic                   inTrapValid;
  logic [WORD_LENGTH-1:0] inTrapSeg;
  logic [WORD_LENGTH-1:0] inTrapOfs;
  logic                   inHalt;
  logic                   inResume;
  logic                   outValid;
  logic [WORD_LENGTH-1:0] outPstate0;
  logic [WORD_LENGTH-1:0] outPstate1;
  logic [SW-1:0]          outSlots;
  logic                   outHalted;

  modport master (
    input  inReady, inBrValid, inBrSeg, inBrOfs,
    input  inTrapValid, inTrapSeg, inTrapOfs, inHalt, inResume,
    output outValid, outPstate0, outPstate1, outSlots, outHalted
  );

  modport slave (
    output inReady, inBrValid, inBrSeg, inBrOfs,
    output inTrapValid, inTrapSeg, inTrapOfs, inHalt, inResume,
    input  outValid, outPstate0, outPstate1, outSlots, outHalted
  );
endinterface

// File: rtl/instr_adr_gen.sv
// Instruction address generator: emits segment/offset of each fetch group, handles redirects and halt.
// Latency: 1 cycle from redirect/halt/resume request to the new registered address/state.
// Backpressure: outValid && !inReady holds all outputs; redirects apply regardless of inReady.
// Ports: clk, rst (sync, active high); bus (master modport) carries requests in and the
//        address pair (outPstate0 = segment, outPstate1 = offset), outSlots, outHalted out.
module instr_adr_gen #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     INSTR_BYTES = 4,
  parameter int                     LANES       = 2,
  parameter logic [WORD_LENGTH-1:0] RESET_SEG   = '0,
  parameter logic [WORD_LENGTH-1:0] RESET_OFS   = '0
) (
  input  logic            clk,
  input  logic            rst,
  instr_adr_gen_if.master bus
);

  localparam int SW    = $clog2(LANES) + 1;
  localparam int IB_SH = $clog2(INSTR_BYTES);
  localparam int GB    = LANES * INSTR_BYTES;

  localparam logic [WORD_LENGTH-1:0] ALIGN_MASK = WORD_LENGTH'(INSTR_BYTES - 1);
  localparam logic [WORD_LENGTH-1:0] GB_MASK    = WORD_LENGTH'(GB - 1);
  localparam logic [WORD_LENGTH-1:0] GB_W       = WORD_LENGTH'(GB);
  localparam logic [WORD_LENGTH-1:0] LANE_MASK  = WORD_LENGTH'(LANES - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                 state;
  logic                   valid_q;
  logic                   halted_q;
  logic [WORD_LENGTH-1:0] seg_q;
  logic [WORD_LENGTH-1:0] ofs_q;
  logic [SW-1:0]          slots_q;

  logic [WORD_LENGTH-1:0] seq_ofs;
  logic [WORD_LENGTH-1:0] br_ofs;
  logic [WORD_LENGTH-1:0] trap_ofs;
  logic                   xfer;

  // Slots left in the group starting at offset o: a group entered mid-way
  // (after a redirect) only has the lanes from the entry point to the end.
  function automatic logic [SW-1:0] slots_of(input logic [WORD_LENGTH-1:0] o);
    logic [WORD_LENGTH-1:0] idx;
    idx = (o >> IB_SH) & LANE_MASK;
    return SW'(LANES) - SW'(idx);
  endfunction

  // Sequential advance always lands on the next group boundary, even when the
  // current group was entered unaligned; the add wraps naturally at 2^WORD_LENGTH.
  assign seq_ofs  = (ofs_q & ~GB_MASK) + GB_W;
  assign br_ofs   = bus.inBrOfs & ~ALIGN_MASK;
  assign trap_ofs = bus.inTrapOfs & ~ALIGN_MASK;
  assign xfer     = valid_q && bus.inReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset drops everything, including any redirect presented this cycle.
      state    <= S_RESET;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      seg_q    <= RESET_SEG;
      ofs_q    <= RESET_OFS;
      slots_q  <= slots_of(RESET_OFS);
    end else begin
      case (state)
        S_RESET: begin
          // Reset vector is already loaded; just start offering it.
          state   <= S_RUN;
          valid_q <= 1'b1;
        end

        S_RUN: begin
          if (bus.inTrapValid) begin
            // Trap beats both branch and halt; the unit stays running.
            seg_q   <= bus.inTrapSeg;
            ofs_q   <= trap_ofs;
            slots_q <= slots_of(trap_ofs);
            valid_q <= 1'b1;
          end else if (bus.inBrValid) begin
            seg_q   <= bus.inBrSeg;
            ofs_q   <= br_ofs;
            slots_q <= slots_of(br_ofs);
            if (bus.inHalt) begin
              // Branch target is what we resume from after the halt.
              state    <= S_HALT;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              valid_q  <= 1'b1;
            end
          end else if (bus.inHalt) begin
            // Halt freezes the current address even if it was accepted this cycle.
            state    <= S_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (xfer) begin
            ofs_q   <= seq_ofs;
            slots_q <= slots_of(seq_ofs);
          end
          // inResume has no meaning while running.
        end

        S_HALT: begin
          if (bus.inTrapValid) begin
            seg_q    <= bus.inTrapSeg;
            ofs_q    <= trap_ofs;
            slots_q  <= slots_of(trap_ofs);
            state    <= S_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end else if (bus.inResume) begin
            state    <= S_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end
          // Branches and further halt requests are ignored while halted.
        end

        default: begin
          // Unused encoding: fall back to a clean reset-like state.
          state    <= S_RESET;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
          seg_q    <= RESET_SEG;
          ofs_q    <= RESET_OFS;
          slots_q  <= slots_of(RESET_OFS);
        end
      endcase
    end
  end

  assign bus.outValid   = valid_q;
  assign bus.outPstate0 = seg_q;
  assign bus.outPstate1 = ofs_q;
  assign bus.outSlots   = slots_q;
  assign bus.outHalted  = halted_q;

endmodule

// File: tb/tb_instr_adr_gen.sv
// Bench for instr_adr_gen: directed test-plan scenarios plus a random phase,
// checked against a behavioural model through a per-cycle expectation queue.
module tb_instr_adr_gen;

  localparam int W   = 32;
  localparam int IB  = 4;
  localparam int LN  = 2;
  localparam int GBY = LN * IB;
  localparam int SW  = $clog2(LN) + 1;

  localparam int M_RESET = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

  typedef struct {
    logic          valid;
    logic [W-1:0]  seg;
    logic [W-1:0]  ofs;
    logic [SW-1:0] slots;
    logic          halted;
  } exp_t;

  logic clk;
  logic rst;

  instr_adr_gen_if #(.WORD_LENGTH(W), .LANES(LN)) bus ();

  instr_adr_gen #(
    .WORD_LENGTH(W),
    .INSTR_BYTES(IB),
    .LANES      (LN),
    .RESET_SEG  ('0),
    .RESET_OFS  ('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t exp_q[$];

  // Stimulus for the next edge; request pulses clear after each cycle.
  logic         d_rst, d_rdy, d_br, d_tr, d_halt, d_res;
  logic [W-1:0] d_bseg, d_bofs, d_tseg, d_tofs;

  // Behavioural model state.
  int           m_state;
  logic         m_valid, m_halted;
  logic [W-1:0] m_seg, m_ofs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [SW-1:0] m_slots(input logic [W-1:0] o);
    int unsigned lane;
    lane = (o / IB) % LN;
    return SW'(LN - lane);
  endfunction

  function automatic logic [W-1:0] m_align(input logic [W-1:0] o);
    return (o / IB) * IB;
  endfunction

  task automatic model_update();
    logic [W-1:0] nxt;
    if (d_rst) begin
      m_state = M_RESET; m_valid = 0; m_halted = 0; m_seg = '0; m_ofs = '0;
    end else begin
      case (m_state)
        M_RESET: begin m_state = M_RUN; m_valid = 1; end
        M_RUN: begin
          if (d_tr) begin
            m_seg = d_tseg; m_ofs = m_align(d_tofs); m_valid = 1;
          end else if (d_br) begin
            m_seg = d_bseg; m_ofs = m_align(d_bofs);
            if (d_halt) begin m_state = M_HALT; m_valid = 0; m_halted = 1; end
          end else if (d_halt) begin
            m_state = M_HALT; m_valid = 0; m_halted = 1;
          end else if (m_valid && d_rdy) begin
            nxt = (m_ofs / GBY) * GBY + GBY;
            m_ofs = nxt;
          end
        end
        default: begin
          if (d_tr) begin
            m_seg = d_tseg; m_ofs = m_align(d_tofs);
            m_state = M_RUN; m_valid = 1; m_halted = 0;
          end else if (d_res) begin
            m_state = M_RUN; m_valid = 1; m_halted = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: apply stimulus, predict, then compare after the edge.
  task automatic cyc();
    exp_t e;
    rst             = d_rst;
    bus.inReady     = d_rdy;
    bus.inBrValid   = d_br;
    bus.inBrSeg     = d_bseg;
    bus.inBrOfs     = d_bofs;
    bus.inTrapValid = d_tr;
    bus.inTrapSeg   = d_tseg;
    bus.inTrapOfs   = d_tofs;
    bus.inHalt      = d_halt;
    bus.inResume    = d_res;
    model_update();
    exp_q.push_back('{m_valid, m_seg, m_ofs, m_slots(m_ofs), m_halted});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid",  64'(bus.outValid),   64'(e.valid));
    chk("seg",    64'(bus.outPstate0), 64'(e.seg));
    chk("ofs",    64'(bus.outPstate1), 64'(e.ofs));
    chk("slots",  64'(bus.outSlots),   64'(e.slots));
    chk("halted", 64'(bus.outHalted),  64'(e.halted));
    d_br = 0; d_tr = 0; d_halt = 0; d_res = 0;
    @(negedge clk);
  endtask

  task automatic branch(input logic [W-1:0] s, input logic [W-1:0] o);
    d_br = 1; d_bseg = s; d_bofs = o;
  endtask

  task automatic trap(input logic [W-1:0] s, input logic [W-1:0] o);
    d_tr = 1; d_tseg = s; d_tofs = o;
  endtask

  initial begin
    d_rst = 1; d_rdy = 1; d_br = 0; d_tr = 0; d_halt = 0; d_res = 0;
    d_bseg = '0; d_bofs = '0; d_tseg = '0; d_tofs = '0;
    m_state = M_RESET; m_valid = 0; m_halted = 0; m_seg = '0; m_ofs = '0;
    rst = 1;
    bus.inReady = 0; bus.inBrValid = 0; bus.inBrSeg = '0; bus.inBrOfs = '0;
    bus.inTrapValid = 0; bus.inTrapSeg = '0; bus.inTrapOfs = '0;
    bus.inHalt = 0; bus.inResume = 0;
    @(negedge clk);

    // 1. Reset then sequential run.
    cyc(); cyc();
    chk("rst_valid", 64'(bus.outValid), 64'd0);
    d_rst = 0;
    cyc();
    chk("run_ofs0",   64'(bus.outPstate1), 64'h0);
    chk("run_slots0", 64'(bus.outSlots),   64'd2);
    chk("run_valid",  64'(bus.outValid),   64'd1);
    cyc(); chk("run_ofs8",  64'(bus.outPstate1), 64'h8);
    cyc(); chk("run_ofs10", 64'(bus.outPstate1), 64'h10);
    chk("run_seg0", 64'(bus.outPstate0), 64'h0);

    // 2. Unaligned branch.
    branch(32'h5, 32'h1006); cyc();
    chk("br_seg",   64'(bus.outPstate0), 64'h5);
    chk("br_ofs",   64'(bus.outPstate1), 64'h1004);
    chk("br_slots", 64'(bus.outSlots),   64'd1);
    cyc();
    chk("br_next_ofs",   64'(bus.outPstate1), 64'h1008);
    chk("br_next_slots", 64'(bus.outSlots),   64'd2);

    // 3. Stall, then resume while running (ignored).
    branch(32'h0, 32'h20); cyc();
    d_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ofs",   64'(bus.outPstate1), 64'h20);
      chk("stall_valid", 64'(bus.outValid),   64'd1);
    end
    d_rdy = 1; cyc();
    chk("stall_release", 64'(bus.outPstate1), 64'h28);
    d_rdy = 0; d_res = 1; cyc();
    chk("resume_in_run", 64'(bus.outPstate1), 64'h28);
    d_rdy = 1;

    // 4. Trap and branch together.
    trap(32'h7, 32'h100); branch(32'h5, 32'h200); cyc();
    chk("tb_seg", 64'(bus.outPstate0), 64'h7);
    chk("tb_ofs", 64'(bus.outPstate1), 64'h100);

    // 5. Halt / resume / trap out of halt.
    branch(32'h0, 32'h40); cyc();
    d_halt = 1; cyc();
    chk("halt_valid",  64'(bus.outValid),   64'd0);
    chk("halt_flag",   64'(bus.outHalted),  64'd1);
    chk("halt_ofs",    64'(bus.outPstate1), 64'h40);
    branch(32'h0, 32'h500); d_halt = 1; cyc();
    chk("halt_br_ign", 64'(bus.outPstate1), 64'h40);
    d_res = 1; cyc();
    chk("resume_valid", 64'(bus.outValid),   64'd1);
    chk("resume_ofs",   64'(bus.outPstate1), 64'h40);
    d_halt = 1; cyc();
    trap(32'h0, 32'h300); cyc();
    chk("halt_trap_valid", 64'(bus.outValid),   64'd1);
    chk("halt_trap_ofs",   64'(bus.outPstate1), 64'h300);
    branch(32'h3, 32'h600); d_halt = 1; cyc();
    chk("halt_br_seg",  64'(bus.outPstate0), 64'h3);
    chk("halt_br_ofs",  64'(bus.outPstate1), 64'h600);
    chk("halt_br_flag", 64'(bus.outHalted),  64'd1);
    trap(32'h0, 32'h700); d_res = 1; cyc();
    chk("trap_res_ofs", 64'(bus.outPstate1), 64'h700);
    trap(32'h1, 32'h800); d_halt = 1; cyc();
    chk("halt_trap_run", 64'(bus.outHalted),  64'd0);
    chk("halt_trap_seg", 64'(bus.outPstate0), 64'h1);

    // 6. Wrap, then reset over a pending branch.
    branch(32'h9, 32'hFFFF_FFF8); cyc();
    cyc();
    chk("wrap_ofs", 64'(bus.outPstate1), 64'h0);
    chk("wrap_seg", 64'(bus.outPstate0), 64'h9);
    d_rst = 1; branch(32'h4, 32'h900); cyc();
    chk("rst_br_ofs",   64'(bus.outPstate1), 64'h0);
    chk("rst_br_valid", 64'(bus.outValid),   64'd0);
    d_rst = 0; cyc();
    chk("rst_vec_seg", 64'(bus.outPstate0), 64'h0);
    chk("rst_vec_ofs", 64'(bus.outPstate1), 64'h0);

    // Random phase against the model.
    for (int i = 0; i < 400; i++) begin
      d_rst  = ($urandom_range(0, 63) == 0);
      d_rdy  = ($urandom_range(0, 3) != 0);
      d_halt = ($urandom_range(0, 15) == 0);
      d_res  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)  branch($urandom, $urandom);
      if ($urandom_range(0, 15) == 0) trap($urandom, $urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
